// File: rtl/serial_add_ctrl_pkg.sv
// Shared definitions for the serial adder controller: state encoding,
// default operand width and the bit-counter sizing rule.
package serial_add_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CLR  = 3'd1,
        LOAD = 3'd2,
        ADD  = 3'd3,
        DONE = 3'd4
    } state_e;

    // Plain vector constants so the controller can keep its state in a logic register.
    localparam logic [2:0] ST_IDLE = IDLE;
    localparam logic [2:0] ST_CLR  = CLR;
    localparam logic [2:0] ST_LOAD = LOAD;
    localparam logic [2:0] ST_ADD  = ADD;
    localparam logic [2:0] ST_DONE = DONE;

    function automatic int counter_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_add_ctrl_phase_counter.sv
// Bit counter for the LOAD and ADD phases; tc flags the last bit of a phase.
module phase_counter
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = counter_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= (count == LAST) ? '0 : count + CW'(1);
        end
    end

    assign tc = (count == LAST);

endmodule

// File: rtl/serial_add_ctrl.sv
// Controller that clears, loads and recirculates a downstream serial adder,
// feeding it both operands LSB first and flagging completion with done.
module serial_add_ctrl
    import serial_add_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             shift_control,
    output logic             serial_input,
    output logic             serial_input_A,
    output logic             select_A,
    output logic             clear
);

    logic [2:0]       state;
    logic [2:0]       state_next;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             tc;
    logic             phase_clr;
    logic             phase_en;
    logic             accept;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_CLR;
            ST_CLR:  state_next = ST_LOAD;
            ST_LOAD: if (tc) state_next = ST_ADD;
            ST_ADD:  if (tc) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign accept    = (state == ST_IDLE) && start;
    assign phase_en  = (state == ST_LOAD) || (state == ST_ADD);
    assign phase_clr = (state_next != state);

    phase_counter #(
        .WIDTH (WIDTH)
    ) u_phase_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (phase_clr),
        .en    (phase_en),
        .tc    (tc)
    );

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            a_sh           <= '0;
            b_sh           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            shift_control  <= 1'b0;
            select_A       <= 1'b0;
            serial_input   <= 1'b0;
            serial_input_A <= 1'b0;
            clear          <= 1'b0;
        end else begin
            state         <= state_next;
            busy          <= (state_next == ST_CLR) || (state_next == ST_LOAD) ||
                             (state_next == ST_ADD);
            done          <= (state_next == ST_DONE);
            shift_control <= (state_next == ST_LOAD) || (state_next == ST_ADD);
            select_A      <= (state_next == ST_ADD);
            clear         <= (state_next != ST_CLR);

            if (accept) begin
                a_sh <= a_in;
                b_sh <= b_in;
            end else if (state_next == ST_LOAD) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
            end

            // Each LOAD cycle presents the current LSB while the copy shifts toward the next bit.
            if (state_next == ST_LOAD) begin
                serial_input_A <= a_sh[0];
                serial_input   <= b_sh[0];
            end else begin
                serial_input_A <= 1'b0;
                serial_input   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: a 4-bit and an 8-bit instance share
// stimulus and are compared every cycle against a cycle-position reference model.
module tb_serial_add_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] a4, b4;
    logic [7:0] a8, b8;

    logic busy4, done4, shift4, sb4, sa4, sel4, clr4;
    logic busy8, done8, shift8, sb8, sa8, sel8, clr8;
    logic [6:0] o4, o8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: pos = -1 idle, 0 clear cycle, 1..W load bits, W+1..2W add, 2W+1 done
    int         pos [2];
    logic [7:0] la  [2];
    logic [7:0] lb  [2];
    int         done4_q[$];
    int         done8_q[$];
    logic [6:0] e4, e8;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_sa;
        logic [3:0] exp_sb;
        int         exp_done;
    } vec_t;

    vec_t tbl[4];

    serial_add_ctrl #(.WIDTH(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .a_in           (a4),
        .b_in           (b4),
        .busy           (busy4),
        .done           (done4),
        .shift_control  (shift4),
        .serial_input   (sb4),
        .serial_input_A (sa4),
        .select_A       (sel4),
        .clear          (clr4)
    );

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .a_in           (a8),
        .b_in           (b8),
        .busy           (busy8),
        .done           (done8),
        .shift_control  (shift8),
        .serial_input   (sb8),
        .serial_input_A (sa8),
        .select_A       (sel8),
        .clear          (clr8)
    );

    assign o4 = {busy4, done4, shift4, sel4, sa4, sb4, clr4};
    assign o8 = {busy8, done8, shift8, sel8, sa8, sb8, clr8};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Bit order: busy, done, shift_control, select_A, serial_input_A, serial_input, clear
    function automatic logic [6:0] model_out(input int p, input int w, input logic [7:0] a,
                                             input logic [7:0] b, input logic r);
        if (r)          return 7'b0000000;
        if (p < 0)      return 7'b0000001;
        if (p == 0)     return 7'b1000000;
        if (p <= w)     return {1'b1, 1'b0, 1'b1, 1'b0, a[p-1], b[p-1], 1'b1};
        if (p <= 2 * w) return 7'b1011001;
        return 7'b0100001;
    endfunction

    initial begin
        pos[0] = -1;
        pos[1] = -1;
        la[0] = '0; la[1] = '0; lb[0] = '0; lb[1] = '0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int w;
            w = (i == 0) ? 4 : 8;
            if (reset) begin
                pos[i] = -1;
            end else if (pos[i] < 0) begin
                if (start) begin
                    pos[i] = 0;
                    la[i]  = (i == 0) ? {4'h0, a4} : a8;
                    lb[i]  = (i == 0) ? {4'h0, b4} : b8;
                end
            end else if (pos[i] == 2 * w + 1) begin
                pos[i] = -1;
            end else begin
                pos[i] = pos[i] + 1;
            end
        end
        #1;
        e4 = model_out(pos[0], 4, la[0], lb[0], reset);
        e8 = model_out(pos[1], 8, la[1], lb[1], reset);
        checkOutput("w4 cycle outputs", {25'd0, o4}, {25'd0, e4});
        checkOutput("w8 cycle outputs", {25'd0, o8}, {25'd0, e8});
        if (o4[5]) done4_q.push_back(cyc);
        if (o8[5]) done8_q.push_back(cyc);
    end

    function automatic int count_done(input int sel, input int lo, input int hi);
        int n = 0;
        if (sel == 0) begin
            foreach (done4_q[k]) if (done4_q[k] >= lo && done4_q[k] <= hi) n++;
        end else begin
            foreach (done8_q[k]) if (done8_q[k] >= lo && done8_q[k] <= hi) n++;
        end
        return n;
    endfunction

    task automatic wait_idle(input int limit);
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (pos[0] < 0 && pos[1] < 0) return;
        end
        checkOutput("idle wait timeout", 32'd1, 32'd0);
    endtask

    // Accept edge index is returned in n0; the call ends in the clear cycle.
    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                                 input logic [7:0] a8v, input logic [7:0] b8v, output int n0);
        @(negedge clk);
        a4 = a; b4 = b; a8 = a8v; b8 = b8v;
        start = 1'b1;
        @(posedge clk);
        #1 n0 = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic observe(input int sel, input int w, output logic [7:0] sa, output logic [7:0] sb,
                           output int ld, output int ad, output int de);
        logic [6:0] o;
        sa = '0; sb = '0; ld = 0; ad = 0; de = -1;
        for (int k = 0; k < 2 * w + 4; k++) begin
            @(posedge clk);
            #1 o = (sel == 0) ? o4 : o8;
            if (o[4] && !o[3]) begin
                ld++;
                sa = {sa[6:0], o[2]};
                sb = {sb[6:0], o[1]};
            end
            if (o[4] && o[3]) ad++;
            if (o[5]) begin
                de = cyc;
                break;
            end
        end
    endtask

    initial begin
        int n0;
        logic [7:0] sa, sb;
        int ld, ad, de;

        // Streams are written in time order, first bit at the MSB
        tbl[0] = '{a: 4'b1011, b: 4'b0110, exp_sa: 4'b1101, exp_sb: 4'b0110, exp_done: 9};
        tbl[1] = '{a: 4'b0001, b: 4'b1000, exp_sa: 4'b1000, exp_sb: 4'b0001, exp_done: 9};
        tbl[2] = '{a: 4'b1111, b: 4'b0000, exp_sa: 4'b1111, exp_sb: 4'b0000, exp_done: 9};
        tbl[3] = '{a: 4'b0100, b: 4'b1110, exp_sa: 4'b0010, exp_sb: 4'b0111, exp_done: 9};

        reset = 1'b1; start = 1'b0;
        a4 = '0; b4 = '0; a8 = '0; b8 = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset outputs w4", {25'd0, o4}, 32'd0);
        checkOutput("reset outputs w8", {25'd0, o8}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("post-reset outputs w4", {25'd0, o4}, 32'd1);
        checkOutput("post-reset outputs w8", {25'd0, o8}, 32'd1);

        // Spec's "done at cycle N+10" is the period after edge N+9
        for (int i = 0; i < 4; i++) begin
            wait_idle(40);
            applyStimulus(tbl[i].a, tbl[i].b, 8'($urandom), 8'($urandom), n0);
            a4 = 4'($urandom); b4 = 4'($urandom);
            observe(0, 4, sa, sb, ld, ad, de);
            checkOutput("table serial A", {24'd0, sa}, {28'd0, tbl[i].exp_sa});
            checkOutput("table serial B", {24'd0, sb}, {28'd0, tbl[i].exp_sb});
            checkOutput("table load cycles", ld, 4);
            checkOutput("table add cycles", ad, 4);
            checkOutput("table done latency", de - n0, tbl[i].exp_done);
        end

        // start pulses during LOAD and ADD are ignored
        wait_idle(40);
        applyStimulus(4'hA, 4'h5, 8'h11, 8'h22, n0);
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle(40);
        checkOutput("ignored starts done count", count_done(0, n0 + 1, n0 + 20), 1);
        checkOutput("ignored starts done time", count_done(0, n0 + 9, n0 + 9), 1);

        // reset in the first ADD cycle aborts without a done pulse
        wait_idle(40);
        applyStimulus(4'h9, 4'h3, 8'h5A, 8'hC3, n0);
        repeat (5) @(negedge clk);
        checkOutput("in add before reset", {31'd0, sel4}, 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("async reset w4", {25'd0, o4}, 32'd0);
        checkOutput("async reset w8", {25'd0, o8}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        wait_idle(40);
        repeat (12) @(negedge clk);
        checkOutput("aborted op done w4", count_done(0, n0, cyc), 0);
        checkOutput("aborted op done w8", count_done(1, n0, cyc), 0);
        applyStimulus(4'h6, 4'h7, 8'h00, 8'hFF, n0);
        observe(0, 4, sa, sb, ld, ad, de);
        checkOutput("fresh start done latency", de - n0, 9);

        // start held high: back-to-back runs with one idle cycle between
        wait_idle(60);
        start = 1'b1;
        @(posedge clk);
        #1 n0 = cyc;
        repeat (29) @(negedge clk);
        start = 1'b0;
        wait_idle(60);
        checkOutput("held start first done", count_done(0, n0 + 9, n0 + 9), 1);
        checkOutput("held start second done", count_done(0, n0 + 20, n0 + 20), 1);
        checkOutput("held start done count", count_done(0, n0 + 1, n0 + 21), 2);
        checkOutput("held start w8 first done", count_done(1, n0 + 17, n0 + 17), 1);

        // 8-bit instance: 8 load, 8 add, done after edge N+17
        wait_idle(60);
        applyStimulus(4'h0, 4'h0, 8'hA5, 8'h1E, n0);
        observe(1, 8, sa, sb, ld, ad, de);
        checkOutput("w8 serial A", {24'd0, sa}, 32'hA5);
        checkOutput("w8 serial B", {24'd0, sb}, 32'h78);
        checkOutput("w8 load cycles", ld, 8);
        checkOutput("w8 add cycles", ad, 8);
        checkOutput("w8 done latency", de - n0, 17);

        // Random traffic with occasional resets, checked by the per-cycle model
        wait_idle(60);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            a4 = 4'($urandom); b4 = 4'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom);
            start = ($urandom_range(0, 3) == 0);
            if (reset) reset = 1'b0;
            else       reset = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        wait_idle(60);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving operand width and the number of shift cycles per phase.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 SHALL have port a_in  input  WIDTH  operand A, latched when start is accepted.
REQ-006 SHALL have port b_in  input  WIDTH  operand B, latched when start is accepted.
REQ-007 SHALL have port busy  output  1  high from CLR through ADD inclusive.
REQ-008 SHALL have port done  output  1  one-cycle pulse in the DONE state.
REQ-009 SHALL have port shift_control  output  1  shift enable to the downstream serial adder.
REQ-010 SHALL have port serial_input  output  1  serial B bit to the downstream adder, LSB first.
REQ-011 SHALL have port serial_input_A  output  1  serial A bit to the downstream adder, LSB first.
REQ-012 SHALL have port select_A  output  1  0 = load A from serial_input_A; 1 = recirculate the sum into A.
REQ-013 SHALL have port clear  output  1  active-low clear to the downstream adder registers and carry.

Function
REQ-014 SHALL implement the FSM states IDLE, CLR, LOAD, ADD, DONE; all outputs SHALL be registered.
REQ-015 In IDLE with start=1 at edge N, SHALL latch a_in and b_in and enter CLR, so that CLR occupies cycle N+1.
REQ-016 CLR SHALL last exactly 1 cycle with clear=0, shift_control=0, then go to LOAD.
REQ-017 LOAD SHALL last exactly WIDTH cycles with shift_control=1, select_A=0, and serial_input_A/serial_input = a[k]/b[k] in the k-th cycle (k = 0..WIDTH-1).
REQ-018 ADD SHALL last exactly WIDTH cycles with shift_control=1, select_A=1, serial_input=0 and serial_input_A=0.
REQ-019 DONE SHALL last 1 cycle with done=1, busy=0, shift_control=0, then go to IDLE.
REQ-020 In IDLE, CLR-exit and DONE, clear SHALL be 1, select_A SHALL be 0, and the serial outputs SHALL be 0.
REQ-021 Start latency SHALL be fixed: done is high in cycle N+2*WIDTH+2 after acceptance at edge N.
REQ-022 The bit counter SHALL be ceil(log2(WIDTH)) bits wide, SHALL clear on each phase entry, and its terminal count WIDTH-1 SHALL advance the phase with no extra cycle.
REQ-023 start while busy or in DONE SHALL be ignored and SHALL not be queued; changes to a_in/b_in after acceptance SHALL have no effect.
REQ-024 start held high continuously SHALL be re-accepted in IDLE, giving back-to-back operations with exactly one IDLE cycle between them.

Reset
REQ-025 While reset=1, state SHALL be IDLE, counter 0, latched operands 0, and busy=done=shift_control=select_A=serial_input=serial_input_A=0.
REQ-026 While reset=1, clear SHALL be 0 so the downstream adder is held cleared; after release, clear SHALL be 1.
REQ-027 Reset asserted mid-operation SHALL abort immediately and asynchronously, and SHALL produce no done pulse.

Structure
REQ-028 A shared package SHALL hold the FSM state enum and the default WIDTH constant.
REQ-029 The bit counter SHALL be a sub-module, phase_counter, with inputs clk, reset, clr and en, and output tc.

Verification
REQ-030 Reset asserted then released -> all outputs 0 except clear, which is 0 during reset and 1 after release; state IDLE.
REQ-031 a_in=4'b1011, b_in=4'b0110, start 1 cycle -> CLR 1 cycle; LOAD serial_input_A=1,1,0,1 and serial_input=0,1,1,0; ADD 4 cycles with select_A=1; done at cycle N+10.
REQ-032 start pulsed during LOAD cycle 2 and during ADD -> ignored; exactly one done pulse at N+10.
REQ-033 start held high for 30 cycles -> done at N+10 and N+21; exactly one IDLE cycle between operations.
REQ-034 reset pulsed during ADD cycle 1 -> all outputs 0 and clear=0 immediately; no done pulse; a fresh start afterwards completes normally.
REQ-035 WIDTH=8, a_in=8'hA5 -> LOAD and ADD each last 8 cycles, serial_input_A=1,0,1,0,0,1,0,1, done at N+18.
